// File: rtl/snow_addr_gen.sv
// Snow sprite position tracker and scan-to-ROM address generator with a free-running animation tick counter.
// Optional horizontal wind drift is built only when SNOW_WIND_EN is defined.
module snow_addr_gen #(
    parameter int unsigned TICK_MAX     = 6000000,
    parameter int unsigned X_INIT       = 288,
    parameter int unsigned FALL_STEP    = 2,
    parameter int unsigned DRIFT_FRAMES = 4,
    parameter int unsigned H_ACTIVE     = 640,
    parameter int unsigned V_ACTIVE     = 480
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [9:0]  col_addr,
    input  logic [8:0]  row_addr,
    input  logic        frame_tick,
    output logic [11:0] snow_addr,
    output logic        snow_hit,
    output logic [31:0] ipcnt,
    output logic        anim_tick
);

    localparam logic [31:0] TICK_C   = 32'(TICK_MAX);
    localparam logic [9:0]  X_INIT_C = 10'(X_INIT);
    localparam logic [9:0]  STEP_C   = 10'(FALL_STEP);
    localparam logic [9:0]  VACT_C   = 10'(V_ACTIVE);

    if (X_INIT > H_ACTIVE - 64 || FALL_STEP < 1 || FALL_STEP > 63 ||
        DRIFT_FRAMES < 1 || DRIFT_FRAMES > 255) begin : g_bad_param
        $error("snow_addr_gen: parameter out of range");
    end

    logic [31:0] ipcnt_q, ipcnt_d;
    logic        anim_tick_q, anim_tick_d;
    logic [11:0] snow_addr_q, snow_addr_d;
    logic        snow_hit_q, snow_hit_d;
    logic [8:0]  pos_y_q, pos_y_d;
    logic [9:0]  pos_x_q;
    logic [10:0] dx, dy;
    logic [9:0]  y_sum;
    logic        hit;

    // anim_tick is compared against the next count so the pulse lines up with ipcnt == TICK_MAX
    always_comb begin
        ipcnt_d     = (ipcnt_q == TICK_C) ? 32'd0 : ipcnt_q + 32'd1;
        anim_tick_d = (ipcnt_d == TICK_C);
    end

    always_comb begin
        dx          = {1'b0, col_addr} - {1'b0, pos_x_q};
        dy          = {2'b00, row_addr} - {2'b00, pos_y_q};
        hit         = (col_addr >= pos_x_q) && (dx < 11'd64) &&
                      (row_addr >= pos_y_q) && (dy < 11'd64);
        snow_hit_d  = hit;
        snow_addr_d = hit ? {dy[5:0], dx[5:0]} : 12'd0;
    end

    always_comb begin
        y_sum   = {1'b0, pos_y_q} + STEP_C;
        pos_y_d = pos_y_q;
        if (frame_tick) begin
            pos_y_d = (y_sum >= VACT_C) ? 9'd0 : y_sum[8:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ipcnt_q     <= 32'd0;
            anim_tick_q <= 1'b0;
            snow_addr_q <= 12'd0;
            snow_hit_q  <= 1'b0;
            pos_y_q     <= 9'd0;
        end else begin
            ipcnt_q     <= ipcnt_d;
            anim_tick_q <= anim_tick_d;
            snow_addr_q <= snow_addr_d;
            snow_hit_q  <= snow_hit_d;
            pos_y_q     <= pos_y_d;
        end
    end

`ifdef SNOW_WIND_EN
    // state   | meaning
    // DRIFT_R | drifting right, pos_x rises on each step
    // DRIFT_L | drifting left, pos_x falls on each step
    typedef enum logic {DRIFT_R, DRIFT_L} drift_t;

    localparam logic [9:0] X_MAX_C      = 10'(H_ACTIVE - 64);
    localparam logic [7:0] DRIFT_LAST_C = 8'(DRIFT_FRAMES - 1);

    drift_t     drift_q, drift_d;
    logic [7:0] drift_cnt_q, drift_cnt_d;
    logic [9:0] pos_x_d;

    always_comb begin
        drift_d     = drift_q;
        drift_cnt_d = drift_cnt_q;
        pos_x_d     = pos_x_q;
        if (frame_tick) begin
            if (drift_cnt_q == DRIFT_LAST_C) begin
                drift_cnt_d = 8'd0;
                // hitting an edge reverses direction without moving that frame
                case (drift_q)
                    DRIFT_R: begin
                        if (pos_x_q == X_MAX_C) drift_d = DRIFT_L;
                        else                    pos_x_d = pos_x_q + 10'd1;
                    end
                    DRIFT_L: begin
                        if (pos_x_q == 10'd0) drift_d = DRIFT_R;
                        else                  pos_x_d = pos_x_q - 10'd1;
                    end
                    default: drift_d = DRIFT_R;
                endcase
            end else begin
                drift_cnt_d = drift_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            drift_q     <= DRIFT_R;
            drift_cnt_q <= 8'd0;
            pos_x_q     <= X_INIT_C;
        end else begin
            drift_q     <= drift_d;
            drift_cnt_q <= drift_cnt_d;
            pos_x_q     <= pos_x_d;
        end
    end
`else
    assign pos_x_q = X_INIT_C;
`endif

    assign ipcnt     = ipcnt_q;
    assign anim_tick = anim_tick_q;
    assign snow_addr = snow_addr_q;
    assign snow_hit  = snow_hit_q;

endmodule

// File: tb/tb_snow_addr_gen.sv
// Directed self-checking bench for snow_addr_gen: address table, counter wrap, fall wrap, resets and drift.
module tb_snow_addr_gen;

    logic        clk = 1'b0;
    logic        rstn;
    logic [9:0]  col, col_w;
    logic [8:0]  row, row_w;
    logic        ft, ft_w;
    logic [11:0] addr, addr_w;
    logic        hit, hit_w;
    logic [31:0] ipcnt, ipcnt_w;
    logic        anim, anim_w;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    snow_addr_gen #(.TICK_MAX(9), .X_INIT(288), .FALL_STEP(2), .DRIFT_FRAMES(4)) dut (
        .clk(clk), .rstn(rstn), .col_addr(col), .row_addr(row), .frame_tick(ft),
        .snow_addr(addr), .snow_hit(hit), .ipcnt(ipcnt), .anim_tick(anim));

    snow_addr_gen #(.TICK_MAX(9), .X_INIT(575), .FALL_STEP(2), .DRIFT_FRAMES(1)) dut_w (
        .clk(clk), .rstn(rstn), .col_addr(col_w), .row_addr(row_w), .frame_tick(ft_w),
        .snow_addr(addr_w), .snow_hit(hit_w), .ipcnt(ipcnt_w), .anim_tick(anim_w));

    typedef struct {
        logic [9:0]  col;
        logic [8:0]  row;
        logic        hit;
        logic [11:0] addr;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int anim_cnt;
        int exp_y;
        int exp_x;

        // sprite at x=288, y=0
        vecs[0] = '{col: 10'd300, row: 9'd5,  hit: 1'b1, addr: 12'd332};
        vecs[1] = '{col: 10'd352, row: 9'd5,  hit: 1'b0, addr: 12'd0};
        vecs[2] = '{col: 10'd287, row: 9'd5,  hit: 1'b0, addr: 12'd0};
        vecs[3] = '{col: 10'd288, row: 9'd0,  hit: 1'b1, addr: 12'd0};
        vecs[4] = '{col: 10'd351, row: 9'd63, hit: 1'b1, addr: 12'd4095};
        vecs[5] = '{col: 10'd300, row: 9'd64, hit: 1'b0, addr: 12'd0};
        vecs[6] = '{col: 10'd1000, row: 9'd500, hit: 1'b0, addr: 12'd0};

        rstn = 1'b0;
        col = '0; row = '0; ft = 1'b0;
        col_w = '0; row_w = '0; ft_w = 1'b0;
        for (int i = 0; i < 3; i++) begin
            col  = 10'($urandom_range(0, 1023));
            row  = 9'($urandom_range(0, 511));
            ft   = 1'($urandom_range(0, 1));
            col_w = 10'($urandom_range(0, 1023));
            row_w = 9'($urandom_range(0, 511));
            step();
        end
        chk("reset_addr", 32'(addr), 0);
        chk("reset_hit", 32'(hit), 0);
        chk("reset_ipcnt", ipcnt, 0);
        chk("reset_anim", 32'(anim), 0);
        chk("reset_ipcnt_w", ipcnt_w, 0);

        col = '0; row = '0; ft = 1'b0;
        rstn = 1'b1;
        anim_cnt = 0;
        for (int n = 1; n <= 25; n++) begin
            step();
            chk("ipcnt_seq", ipcnt, 32'(n % 10));
            chk("anim_seq", 32'(anim), 32'((n % 10) == 9));
            if (anim) anim_cnt++;
        end
        chk("anim_count", 32'(anim_cnt), 2);

        for (int i = 0; i < 7; i++) begin
            col = vecs[i].col;
            row = vecs[i].row;
            step();
            chk("vec_hit", 32'(hit), 32'(vecs[i].hit));
            chk("vec_addr", 32'(addr), 32'(vecs[i].addr));
        end

        for (int k = 1; k <= 240; k++) begin
            ft = 1'b1;
            step();
            ft = 1'b0;
            exp_y = (2 * k) % 480;
            col = 10'd300;
            row = 9'(exp_y);
            step();
            chk("fall_hit", 32'(hit), 1);
            chk("fall_addr", 32'(addr), 12);
            if (exp_y > 0) begin
                row = 9'(exp_y - 1);
                step();
                chk("fall_above", 32'(hit), 0);
            end
        end

        // frame tick on an in-window pixel: address uses the pre-update row
        col = 10'd300; row = 9'd1; ft = 1'b1;
        step();
        chk("coinc_hit", 32'(hit), 1);
        chk("coinc_addr", 32'(addr), 76);
        ft = 1'b0;
        step();
        chk("coinc_after", 32'(hit), 0);

        // held frame_tick: each high cycle is a frame, 2 + 49*2 = 100
        ft = 1'b1;
        for (int i = 0; i < 49; i++) step();
        ft = 1'b0;
        col = 10'd300; row = 9'd100;
        step();
        chk("y100_hit", 32'(hit), 1);
        chk("y100_addr", 32'(addr), 12);

        ft = 1'b1; rstn = 1'b0;
        step();
        chk("mid_rst_addr", 32'(addr), 0);
        chk("mid_rst_hit", 32'(hit), 0);
        chk("mid_rst_ipcnt", ipcnt, 0);
        chk("mid_rst_anim", 32'(anim), 0);
        rstn = 1'b1; ft = 1'b0;
        col = 10'd288; row = 9'd0;
        step();
        chk("post_rst_hit", 32'(hit), 1);
        chk("post_rst_addr", 32'(addr), 0);
        chk("post_rst_ipcnt", ipcnt, 1);
        col = 10'd300; row = 9'd100;
        step();
        chk("post_rst_old_y", 32'(hit), 0);

        for (int k = 1; k <= 10; k++) begin
            ft_w = 1'b1;
            step();
            ft_w = 1'b0;
`ifdef SNOW_WIND_EN
            exp_x = (k <= 2) ? 576 : 578 - k;
`else
            exp_x = 575;
`endif
            col_w = 10'd576;
            row_w = 9'(2 * k);
            step();
            chk("drift_hit", 32'(hit_w), 1);
            chk("drift_addr", 32'(addr_w), 32'(576 - exp_x));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/snow_addr_gen.md
Name: snow_addr_gen

Overview:
Upstream feeder for the snow sprite display stage. It tracks one 64x64 snow sprite's on-screen position, moves it once per video frame (falling, with optional sideways drift), and converts the current VGA scan coordinate into a 12-bit sprite ROM address plus an in-window flag. It also generates the free-running animation tick counter that the frame-select stage compares against to step the sprite frames.

Parameters:
TICK_MAX, 6000000, terminal value of the ipcnt animation counter; ipcnt wraps to 0 after this value.
X_INIT, 288, sprite left-edge column after reset (0..576).
FALL_STEP, 2, rows the sprite moves down per frame (1..63).
DRIFT_FRAMES, 4, frames between 1-pixel horizontal drift steps (1..255).
H_ACTIVE, 640, active columns.
V_ACTIVE, 480, active rows.

Ports:
clk  in  1  pixel-domain clock; all logic on its rising edge.
rstn  in  1  synchronous active-low reset.
col_addr  in  10  current VGA column, 0..H_ACTIVE-1 while active.
row_addr  in  9  current VGA row, 0..V_ACTIVE-1 while active.
frame_tick  in  1  one-cycle pulse, once per frame in vertical blanking.
snow_addr  out  12  sprite ROM address, registered.
snow_hit  out  1  registered: current pixel lies inside the sprite window.
ipcnt  out  32  animation tick counter.
anim_tick  out  1  registered one-cycle pulse while ipcnt == TICK_MAX.

Behaviour:
- Reset, synchronous, when rstn=0 at a clock edge: snow_addr=0, snow_hit=0, ipcnt=0, anim_tick=0, pos_x=X_INIT, pos_y=0, drift_cnt=0, drift state DRIFT_R. Reset wins over every other event in the same cycle.
- ipcnt: increments by 1 every cycle. When ipcnt == TICK_MAX, the next value is 0. anim_tick=1 exactly on the cycles where ipcnt == TICK_MAX. There is no other stall or clear.
- Window test:
  - dx = col_addr - pos_x and dy = row_addr - pos_y, computed at 11 bits.
  - hit = (col_addr >= pos_x) && (dx < 64) && (row_addr >= pos_y) && (dy < 64).
  - Registered outputs, 1-cycle latency from the coordinate inputs: snow_hit <= hit; snow_addr <= hit ? {dy[5:0], dx[5:0]} : 0.
- Frame update: happens only on cycles with frame_tick=1.
  - Vertical: if pos_y + FALL_STEP >= V_ACTIVE, then pos_y <= 0. Otherwise pos_y <= pos_y + FALL_STEP.
  - The window test in the same cycle uses the pre-update pos_x and pos_y. New values affect the following cycle.
  - Sprite rows beyond V_ACTIVE are simply never scanned; there is no clipping logic.
- Drift FSM, states DRIFT_R and DRIFT_L (active only with SNOW_WIND_EN):
  - On each frame_tick, drift_cnt increments. When it reaches DRIFT_FRAMES-1, it resets to 0 and a step occurs.
  - Step in DRIFT_R: if pos_x == H_ACTIVE-64, go to DRIFT_L with no move. Otherwise pos_x + 1.
  - Step in DRIFT_L: if pos_x == 0, go to DRIFT_R with no move. Otherwise pos_x - 1.
  - pos_x always stays in 0..576.
- frame_tick held high for several cycles: each high cycle counts as a separate frame. Upstream must guarantee a single-cycle pulse.
- Coordinates outside the active area: no special handling. Out-of-window pixels give snow_hit=0 and snow_addr=0.

Optional Feature:
SNOW_WIND_EN
- Defined: the drift FSM and drift_cnt exist, and pos_x moves as described above.
- Undefined: no drift logic is built. pos_x is constant at X_INIT, and only vertical fall and ipcnt operate.

Test Plan:
1. Reset: hold rstn=0 for 3 clocks with random inputs -> snow_addr=0, snow_hit=0, ipcnt=0, anim_tick=0. After release, ipcnt reads 1 on the next clock.
2. Address mapping: with pos_x=288, pos_y=0, drive col=300, row=5 -> one clock later snow_hit=1 and snow_addr=(5<<6)|12=332.
   - col=352, row=5 -> snow_hit=0, snow_addr=0.
   - col=287 -> snow_hit=0.
3. ipcnt wrap: build with TICK_MAX=9 and run 25 clocks after reset -> ipcnt sequence 0..9,0..9,0..4. anim_tick is high on exactly the 2 cycles where ipcnt=9.
4. Fall wrap: build with FALL_STEP=2 and pulse frame_tick 240 times -> pos_y steps 0,2,...,478, then 0. Verify via hit at col=300, row=pos_y.
   - frame_tick coincident with an in-window pixel -> addr still uses the old pos_y.
5. Drift (SNOW_WIND_EN, DRIFT_FRAMES=1, X_INIT=575): frame 1 -> x=576. Frame 2 -> state DRIFT_L, x stays 576. Frame 3 -> x=575.
   - Without the macro: x stays 575 over 10 frames.
6. Mid-run reset: assert rstn=0 while frame_tick=1 at pos_y=100 -> pos_y=0, pos_x=X_INIT, ipcnt=0. The frame update is discarded.
